dense2_mac_layer: RTL and testbench

DENSE2_MAC_LAYER -- requirements
Module: dense2_mac_layer

---
 rtl/dense2_mac_layer_if.sv | 49 ++++
 rtl/dense2_mac_layer.sv | 152 +++++++++++++++
 tb/tb_dense2_mac_layer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dense2_mac_layer_if.sv
// rtl/dense2_mac_layer_if.sv - control, feature/weight/bias read and result write bus of the dense layer
interface dense2_mac_layer_if #(
    parameter int WIDTH = 16
);
    logic             layer_en_i;
    logic             busy_o;
    logic             layer_done_o;
    logic [15:0]      data_from_buf_addr_o;
    logic [WIDTH-1:0] data_from_buf_i;
    logic [15:0]      weight_addr_o;
    logic [WIDTH-1:0] weight_i;
    logic [7:0]       bias_addr_o;
    logic [WIDTH-1:0] bias_i;
    logic [WIDTH-1:0] data_to_buf_o;
    logic [7:0]       data_to_buf_addr_o;
    logic             data_to_buf_we_o;

    // the layer engine side
    modport master (
        input  layer_en_i,
        input  data_from_buf_i,
        input  weight_i,
        input  bias_i,
        output busy_o,
        output layer_done_o,
        output data_from_buf_addr_o,
        output weight_addr_o,
        output bias_addr_o,
        output data_to_buf_o,
        output data_to_buf_addr_o,
        output data_to_buf_we_o
    );

    // the buffer / ROM / controller side
    modport slave (
        output layer_en_i,
        output data_from_buf_i,
        output weight_i,
        output bias_i,
        input  busy_o,
        input  layer_done_o,
        input  data_from_buf_addr_o,
        input  weight_addr_o,
        input  bias_addr_o,
        input  data_to_buf_o,
        input  data_to_buf_addr_o,
        input  data_to_buf_we_o
    );
endinterface

// File: rtl/dense2_mac_layer.sv
// rtl/dense2_mac_layer.sv - sequential fully-connected layer, one MAC per cycle; optional DENSE2_RELU_EN clamps negative results to zero
module dense2_mac_layer #(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 8,
    parameter int IN_LEN  = 120,
    parameter int OUT_LEN = 10
) (
    input  logic clk,
    input  logic rst,
    dense2_mac_layer_if.master bus
);
    localparam int ACC_W = 2*WIDTH + 8;
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [15:0]              r_i;
    logic [7:0]               r_j;
    logic [15:0]              r_waddr;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_pend;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_we;
    logic [WIDTH-1:0]         r_dout;

    logic signed [2*WIDTH-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [SUM_W-1:0]   w_bias_sh;
    logic signed [SUM_W-1:0]   w_sum;
    logic signed [SUM_W-1:0]   w_shift;
    logic [SUM_W-WIDTH:0]      w_hi;
    logic [WIDTH-1:0]          w_sat;
    logic [WIDTH-1:0]          w_result;

    // Product of the pair issued last cycle; r_pend marks that it is real.
    assign w_prod     = $signed(bus.data_from_buf_i) * $signed(bus.weight_i);
    assign w_acc_next = r_pend ? (r_acc + {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod}) : r_acc;

    // The result is formed from the accumulator value that includes the final
    // product (absorbed in DRAIN), so it can be registered into WRITE.
    assign w_bias_sh = {{(SUM_W-WIDTH-FRAC){bus.bias_i[WIDTH-1]}}, bus.bias_i, {FRAC{1'b0}}};
    assign w_sum     = {w_acc_next[ACC_W-1], w_acc_next} + w_bias_sh;
    assign w_shift   = w_sum >>> FRAC;
    assign w_hi      = w_shift[SUM_W-1:WIDTH-1];

    // Clamp to the signed WIDTH range when the upper bits are not a pure sign extension
    always_comb begin
        w_sat = w_shift[WIDTH-1:0];
        if (!((&w_hi) || !(|w_hi))) begin
            w_sat = w_shift[SUM_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Optional rectification of the saturated result
    always_comb begin
        w_result = w_sat;
`ifdef DENSE2_RELU_EN
        if (w_sat[WIDTH-1]) begin
            w_result = '0;
        end
`else
        w_result = w_sat;
`endif
    end

    // Layer sequencer: address generation, accumulation and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_waddr <= '0;
            r_acc   <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_acc  <= w_acc_next;
            r_pend <= 1'b0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.layer_en_i) begin
                        r_state <= S_MAC;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_waddr <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_MAC: begin
                    r_pend <= 1'b1;
                    if (r_i == 16'(IN_LEN-1)) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_i     <= r_i + 16'd1;
                        r_waddr <= r_waddr + 16'd1;
                    end
                end
                S_DRAIN: begin
                    r_state <= S_WRITE;
                    r_we    <= 1'b1;
                    r_dout  <= w_result;
                end
                S_WRITE: begin
                    if (r_j == 8'(OUT_LEN-1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_MAC;
                        r_j     <= r_j + 8'd1;
                        r_i     <= '0;
                        r_waddr <= r_waddr + 16'd1;
                        r_acc   <= '0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_i     <= '0;
                    r_j     <= '0;
                    r_waddr <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o               = r_busy;
    assign bus.layer_done_o         = r_done;
    assign bus.data_from_buf_addr_o = r_i;
    assign bus.weight_addr_o        = r_waddr;
    assign bus.bias_addr_o          = r_j;
    assign bus.data_to_buf_o        = r_dout;
    assign bus.data_to_buf_addr_o   = r_j;
    assign bus.data_to_buf_we_o     = r_we;
endmodule

// File: tb/tb_dense2_mac_layer.sv
// tb/tb_dense2_mac_layer.sv - directed self-checking bench for dense2_mac_layer (IN_LEN=4, OUT_LEN=2)
module tb_dense2_mac_layer;
    logic clk;
    logic rst;

    dense2_mac_layer_if #(.WIDTH(16)) bus ();

    dense2_mac_layer #(
        .WIDTH(16), .FRAC(8), .IN_LEN(4), .OUT_LEN(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] feat_mem [4];
    logic [15:0] w_mem    [8];
    logic [15:0] b_mem    [2];

    // ROM/buffer model: one cycle read latency
    always @(posedge clk) begin
        bus.data_from_buf_i <= (bus.data_from_buf_addr_o < 16'd4) ? feat_mem[bus.data_from_buf_addr_o[1:0]] : 16'h0;
        bus.weight_i        <= (bus.weight_addr_o < 16'd8) ? w_mem[bus.weight_addr_o[2:0]] : 16'h0;
        bus.bias_i          <= (bus.bias_addr_o < 8'd2) ? b_mem[bus.bias_addr_o[0]] : 16'h0;
    end

    int cyc;
    int cyc0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wr_cyc [$];
    logic [15:0] wr_dat [$];
    logic [7:0]  wr_adr [$];
    int          done_cyc [$];
    logic        busy_log [64];

    // Observe DUT outputs on the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.data_to_buf_we_o) begin
                wr_cyc.push_back(cyc - cyc0);
                wr_dat.push_back(bus.data_to_buf_o);
                wr_adr.push_back(bus.data_to_buf_addr_o);
            end
            if (bus.layer_done_o) done_cyc.push_back(cyc - cyc0);
            if ((cyc - cyc0) >= 0 && (cyc - cyc0) < 64) busy_log[cyc - cyc0] = bus.busy_o;
        end
    end

    int n_assert;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] f, input logic [15:0] w, input logic [15:0] b);
        for (int k = 0; k < 4; k++) feat_mem[k] = f;
        for (int k = 0; k < 8; k++) w_mem[k] = w;
        for (int k = 0; k < 2; k++) b_mem[k] = b;
    endtask

    task automatic clear_logs();
        wr_cyc.delete();
        wr_dat.delete();
        wr_adr.delete();
        done_cyc.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy_o), 32'h0);
        check({tag, "_done"}, 32'(bus.layer_done_o), 32'h0);
        check({tag, "_we"}, 32'(bus.data_to_buf_we_o), 32'h0);
        check({tag, "_dout"}, 32'(bus.data_to_buf_o), 32'h0);
        check({tag, "_faddr"}, 32'(bus.data_from_buf_addr_o), 32'h0);
        check({tag, "_waddr"}, 32'(bus.weight_addr_o), 32'h0);
    endtask

    // Single start pulse, wait (bounded) for done, then check both writes and timing
    task automatic run_and_check(input string tag, input logic [15:0] e0, input logic [15:0] e1);
        @(negedge clk);
        clear_logs();
        cyc0 = cyc;
        bus.layer_en_i = 1'b1;
        @(negedge clk);
        bus.layer_en_i = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (done_cyc.size() > 0) break;
        end
        repeat (3) @(negedge clk);
        #1;
        check({tag, "_nwr"}, 32'(wr_cyc.size()), 32'd2);
        if (wr_cyc.size() >= 2) begin
            check({tag, "_adr0"}, 32'(wr_adr[0]), 32'd0);
            check({tag, "_dat0"}, 32'(wr_dat[0]), 32'(e0));
            check({tag, "_cyc0"}, 32'(wr_cyc[0]), 32'd6);
            check({tag, "_adr1"}, 32'(wr_adr[1]), 32'd1);
            check({tag, "_dat1"}, 32'(wr_dat[1]), 32'(e1));
            check({tag, "_cyc1"}, 32'(wr_cyc[1]), 32'd12);
        end
        check({tag, "_ndone"}, 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() >= 1) check({tag, "_done_cyc"}, 32'(done_cyc[0]), 32'd13);
    endtask

    logic [15:0] exp_neg_sat;
    logic [15:0] exp_neg;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cyc      = 0;
        cyc0     = 0;
`ifdef DENSE2_RELU_EN
        exp_neg_sat = 16'h0000;
        exp_neg     = 16'h0000;
`else
        exp_neg_sat = 16'h8000;
        exp_neg     = 16'hFC00;
`endif
        bus.layer_en_i      = 1'b0;
        bus.data_from_buf_i = '0;
        bus.weight_i        = '0;
        bus.bias_i          = '0;
        fill(16'h0100, 16'h0100, 16'h0000);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // 1.0 * 1.0 over 4 inputs -> 4.0, with busy window
        run_and_check("unit", 16'h0400, 16'h0400);
        check("busy_c0", 32'(busy_log[0]), 32'd0);
        check("busy_c1", 32'(busy_log[1]), 32'd1);
        check("busy_c13", 32'(busy_log[13]), 32'd1);
        check("busy_c14", 32'(busy_log[14]), 32'd0);

        // bias only
        fill(16'h0000, 16'h0100, 16'h0180);
        run_and_check("bias", 16'h0180, 16'h0180);

        // positive and negative saturation
        fill(16'h7FFF, 16'h7FFF, 16'h0000);
        run_and_check("satpos", 16'h7FFF, 16'h7FFF);
        fill(16'h7FFF, 16'h8000, 16'h0000);
        run_and_check("satneg", exp_neg_sat, exp_neg_sat);

        // plain negative result
        fill(16'h0100, 16'hFF00, 16'h0000);
        run_and_check("neg", exp_neg, exp_neg);

        // distinct per-address data: n0 = 1+2+3+4 = 10.0, n1 = 0.5*10 + 1.0 = 6.0
        for (int k = 0; k < 4; k++) feat_mem[k] = 16'((k + 1) * 256);
        for (int k = 0; k < 4; k++) w_mem[k] = 16'h0100;
        for (int k = 4; k < 8; k++) w_mem[k] = 16'h0080;
        b_mem[0] = 16'h0000;
        b_mem[1] = 16'h0100;
        run_and_check("addr", 16'h0A00, 16'h0600);

        // reset in cycle 5 of a run: outputs cleared, nothing written afterwards
        fill(16'h0100, 16'h0100, 16'h0000);
        @(negedge clk);
        clear_logs();
        cyc0 = cyc;
        bus.layer_en_i = 1'b1;
        @(negedge clk);
        bus.layer_en_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("midrst_nwr", 32'(wr_cyc.size()), 32'd0);
        check("midrst_ndone", 32'(done_cyc.size()), 32'd0);
        check("midrst_busy", 32'(bus.busy_o), 32'd0);
        run_and_check("after_rst", 16'h0400, 16'h0400);

        // start held high for 30 cycles: back-to-back runs
        @(negedge clk);
        clear_logs();
        cyc0 = cyc;
        bus.layer_en_i = 1'b1;
        repeat (30) @(negedge clk);
        bus.layer_en_i = 1'b0;
        #1;
        check("held_ndone", 32'(done_cyc.size()), 32'd2);
        if (done_cyc.size() >= 2) begin
            check("held_done0", 32'(done_cyc[0]), 32'd13);
            check("held_done1", 32'(done_cyc[1]), 32'd27);
        end
        check("held_nwr", 32'(wr_cyc.size()), 32'd4);
        if (wr_cyc.size() >= 4) begin
            check("held_wr2_cyc", 32'(wr_cyc[2]), 32'd20);
            check("held_wr3_cyc", 32'(wr_cyc[3]), 32'd26);
            check("held_wr3_dat", 32'(wr_dat[3]), 32'h0400);
        end
        rst = 1'b1;
        #1;
        check_zero("final_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
